// File: rtl/cd_rx_ram_pkg.sv
// Shared constants for the receive page buffer, the frame receiver and the
// register block: page geometry, default page count and frame flag bits.
package cd_rx_ram_pkg;

    localparam int PAGE_SIZE        = 256;
    localparam int PAGE_AW          = 8;
    localparam int DEFAULT_PAGE_NUM = 8;

    // Bit positions inside wr_flags / rx_ram_rd_flags.
    localparam int FLAG_CRC_ERR  = 0;
    localparam int FLAG_ALIGN    = 1;
    localparam int FLAG_BCAST    = 2;
    localparam int FLAG_MCAST    = 3;
    localparam int FLAG_TRUNC    = 4;
    localparam int FLAG_RUNT     = 5;
    localparam int FLAG_ADDR_HIT = 6;
    localparam int FLAG_RSVD     = 7;

endpackage

// File: rtl/cd_rx_ram_dpram.sv
// Simple dual-port RAM: one synchronous write port, one asynchronous read port.
// Contents are not reset.
module cd_dpram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cd_rx_ram.sv
// Multi-page receive buffer: the receiver fills and commits pages, the register
// block reads the oldest committed page and releases it (circular page queue).
module cd_rx_ram
    import cd_rx_ram_pkg::*;
#(
    parameter int PAGE_NUM = DEFAULT_PAGE_NUM
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wr_en,
    input  logic [7:0]   wr_addr,
    input  logic [7:0]   wr_byte,
    input  logic [7:0]   wr_flags,
    input  logic         rx_ram_switch,
    output logic         rx_ram_lost,
    input  logic [7:0]   rx_ram_rd_addr,
    output logic [7:0]   rx_ram_rd_byte,
    output logic [7:0]   rx_ram_rd_flags,
    input  logic         rx_ram_rd_done,
    input  logic         rx_clean_all,
    output logic         rx_pending
);

    localparam int PG_W = $clog2(PAGE_NUM);
    localparam logic [PG_W-1:0] COUNT_FULL = PG_W'(PAGE_NUM - 1);

    // All control inputs are single-cycle pulses sampled at the rising edge;
    // rx_ram_lost and rx_pending are registered and appear the following cycle.
    logic [PG_W-1:0] wr_page, wr_page_n;
    logic [PG_W-1:0] rd_page, rd_page_n;
    logic [PG_W-1:0] count, count_n;
    logic            lost_n;
    logic            commit;
    logic [7:0]      flags [PAGE_NUM];
    logic [7:0]      ram_rd;

    // Release (or flush) is applied first so a switch sees the freed slot.
    always_comb begin
        rd_page_n = rd_page;
        wr_page_n = wr_page;
        count_n   = count;
        lost_n    = 1'b0;
        commit    = 1'b0;
        if (rx_clean_all) begin
            rd_page_n = wr_page;
            count_n   = '0;
        end else if (rx_ram_rd_done && (count != '0)) begin
            rd_page_n = rd_page + 1'b1;
            count_n   = count - 1'b1;
        end
        if (rx_ram_switch) begin
            if (count_n != COUNT_FULL) begin
                commit    = 1'b1;
                wr_page_n = wr_page + 1'b1;
                count_n   = count_n + 1'b1;
            end else begin
                lost_n    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_page     <= '0;
            rd_page     <= '0;
            count       <= '0;
            rx_ram_lost <= 1'b0;
            rx_pending  <= 1'b0;
        end else begin
            wr_page     <= wr_page_n;
            rd_page     <= rd_page_n;
            count       <= count_n;
            rx_ram_lost <= lost_n;
            rx_pending  <= (count_n != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            flags[wr_page] <= wr_flags;
        end
    end

    cd_dpram #(
        .WIDTH (8),
        .DEPTH (PAGE_NUM * PAGE_SIZE),
        .AW    (PG_W + PAGE_AW)
    ) u_data_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({wr_page, wr_addr}),
        .wdata (wr_byte),
        .raddr ({rd_page, rx_ram_rd_addr}),
        .rdata (ram_rd)
    );

    // Empty queue hides stale page contents.
    assign rx_ram_rd_byte  = (count == '0) ? 8'h00 : ram_rd;
    assign rx_ram_rd_flags = (count == '0) ? 8'h00 : flags[rd_page];

endmodule

// File: tb/tb_cd_rx_ram.sv
// Directed self-checking bench for cd_rx_ram (PAGE_NUM = 8).
module tb_cd_rx_ram;

    logic       clk;
    logic       reset_n;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_byte;
    logic [7:0] wr_flags;
    logic       rx_ram_switch;
    logic       rx_ram_lost;
    logic [7:0] rx_ram_rd_addr;
    logic [7:0] rx_ram_rd_byte;
    logic [7:0] rx_ram_rd_flags;
    logic       rx_ram_rd_done;
    logic       rx_clean_all;
    logic       rx_pending;

    int n_tests;
    int n_fail;

    cd_rx_ram #(.PAGE_NUM(8)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_byte         (wr_byte),
        .wr_flags        (wr_flags),
        .rx_ram_switch   (rx_ram_switch),
        .rx_ram_lost     (rx_ram_lost),
        .rx_ram_rd_addr  (rx_ram_rd_addr),
        .rx_ram_rd_byte  (rx_ram_rd_byte),
        .rx_ram_rd_flags (rx_ram_rd_flags),
        .rx_ram_rd_done  (rx_ram_rd_done),
        .rx_clean_all    (rx_clean_all),
        .rx_pending      (rx_pending)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: called at a falling edge, return at the next falling edge.
    task automatic drive_cycle(input logic sw, input logic done, input logic clean,
                               input logic [7:0] fl);
        rx_ram_switch  = sw;
        rx_ram_rd_done = done;
        rx_clean_all   = clean;
        wr_flags       = fl;
        @(negedge clk);
        rx_ram_switch  = 1'b0;
        rx_ram_rd_done = 1'b0;
        rx_clean_all   = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_byte = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic commit(input logic [7:0] fl);
        drive_cycle(1'b1, 1'b0, 1'b0, fl);
    endtask

    task automatic release_page();
        drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic set_rd_addr(input logic [7:0] a);
        rx_ram_rd_addr = a;
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (rx_pending !== 1'b0) begin
            n_fail++; $display("FAIL reset_pending got=%0b exp=0", rx_pending);
        end
        n_tests++;
        if (rx_ram_lost !== 1'b0) begin
            n_fail++; $display("FAIL reset_lost got=%0b exp=0", rx_ram_lost);
        end
        n_tests++;
        if (rx_ram_rd_flags !== 8'h00) begin
            n_fail++; $display("FAIL reset_flags got=%02h exp=00", rx_ram_rd_flags);
        end
        apply_reset();
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h11; exp_b[1] = 8'h12; exp_b[2] = 8'h13;
        for (int i = 0; i < 3; i++) write_byte(8'(i), exp_b[i]);
        commit(8'h03);
        n_tests++;
        if (rx_pending !== 1'b1) begin
            n_fail++; $display("FAIL basic_pending got=%0b exp=1", rx_pending);
        end
        for (int i = 0; i < 3; i++) begin
            set_rd_addr(8'(i));
            n_tests++;
            if (rx_ram_rd_byte !== exp_b[i]) begin
                n_fail++; $display("FAIL basic_byte%0d got=%02h exp=%02h", i, rx_ram_rd_byte, exp_b[i]);
            end
        end
        n_tests++;
        if (rx_ram_rd_flags !== 8'h03) begin
            n_fail++; $display("FAIL basic_flags got=%02h exp=03", rx_ram_rd_flags);
        end
        release_page();
        n_tests++;
        if (rx_pending !== 1'b0) begin
            n_fail++; $display("FAIL basic_release_pending got=%0b exp=0", rx_pending);
        end
    endtask

    task automatic fill_seven(input logic [7:0] base);
        for (int i = 0; i < 7; i++) begin
            write_byte(8'h05, base + 8'(i));
            commit(base + 8'(i));
            n_tests++;
            if (rx_ram_lost !== 1'b0) begin
                n_fail++; $display("FAIL fill_lost%0d got=%0b exp=0", i, rx_ram_lost);
            end
        end
    endtask

    task automatic drain_check(input string tag, input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            set_rd_addr(8'h05);
            n_tests++;
            if (rx_pending !== 1'b1 || rx_ram_rd_flags !== first + 8'(i) ||
                rx_ram_rd_byte !== first + 8'(i)) begin
                n_fail++;
                $display("FAIL %s_read%0d got pend=%0b flags=%02h byte=%02h exp pend=1 flags=byte=%02h",
                         tag, i, rx_pending, rx_ram_rd_flags, rx_ram_rd_byte, first + 8'(i));
            end
            release_page();
        end
        n_tests++;
        if (rx_pending !== 1'b0) begin
            n_fail++; $display("FAIL %s_empty_pending got=%0b exp=0", tag, rx_pending);
        end
    endtask

    task automatic test_full_lost();
        fill_seven(8'h10);
        // Two refused switches in a row: one lost pulse each.
        rx_ram_switch = 1'b1;
        wr_flags      = 8'h17;
        @(negedge clk);
        n_tests++;
        if (rx_ram_lost !== 1'b1) begin
            n_fail++; $display("FAIL full_lost_first got=%0b exp=1", rx_ram_lost);
        end
        @(negedge clk);
        rx_ram_switch = 1'b0;
        n_tests++;
        if (rx_ram_lost !== 1'b1) begin
            n_fail++; $display("FAIL full_lost_second got=%0b exp=1", rx_ram_lost);
        end
        @(negedge clk);
        n_tests++;
        if (rx_ram_lost !== 1'b0) begin
            n_fail++; $display("FAIL full_lost_end got=%0b exp=0", rx_ram_lost);
        end
        drain_check("full", 8'h10, 7);
    endtask

    task automatic test_switch_release_full();
        fill_seven(8'h10);
        write_byte(8'h05, 8'h17);
        drive_cycle(1'b1, 1'b1, 1'b0, 8'h17);
        n_tests++;
        if (rx_ram_lost !== 1'b0) begin
            n_fail++; $display("FAIL swrel_lost got=%0b exp=0", rx_ram_lost);
        end
        drain_check("swrel", 8'h11, 7);
    endtask

    task automatic test_clean_switch();
        for (int i = 0; i < 3; i++) begin
            write_byte(8'h05, 8'h21 + 8'(i));
            commit(8'h21 + 8'(i));
        end
        write_byte(8'h05, 8'h24);
        drive_cycle(1'b1, 1'b1, 1'b1, 8'h24);
        drain_check("clean", 8'h24, 1);
    endtask

    task automatic test_idle_done_and_reset();
        release_page();
        n_tests++;
        if (rx_pending !== 1'b0 || rx_ram_rd_flags !== 8'h00) begin
            n_fail++; $display("FAIL idle_done got pend=%0b flags=%02h exp pend=0 flags=00",
                               rx_pending, rx_ram_rd_flags);
        end
        for (int i = 0; i < 4; i++) begin
            write_byte(8'h05, 8'h31 + 8'(i));
            commit(8'h31 + 8'(i));
        end
        set_rd_addr(8'h05);
        n_tests++;
        if (rx_ram_rd_flags !== 8'h31) begin
            n_fail++; $display("FAIL midq_flags got=%02h exp=31", rx_ram_rd_flags);
        end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (rx_pending !== 1'b0 || rx_ram_rd_flags !== 8'h00 || rx_ram_rd_byte !== 8'h00) begin
            n_fail++; $display("FAIL midq_reset got pend=%0b flags=%02h byte=%02h exp 0/00/00",
                               rx_pending, rx_ram_rd_flags, rx_ram_rd_byte);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        write_byte(8'h05, 8'h40);
        commit(8'h40);
        drain_check("postrst", 8'h40, 1);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            write_byte(8'h07, 8'(i) ^ 8'hA5);
            commit(8'(i));
            set_rd_addr(8'h07);
            n_tests++;
            if (rx_ram_lost !== 1'b0 || rx_ram_rd_flags !== 8'(i) ||
                rx_ram_rd_byte !== (8'(i) ^ 8'hA5)) begin
                n_fail++;
                $display("FAIL wrap%0d got lost=%0b flags=%02h byte=%02h exp lost=0 flags=%02h byte=%02h",
                         i, rx_ram_lost, rx_ram_rd_flags, rx_ram_rd_byte, 8'(i), 8'(i) ^ 8'hA5);
            end
            release_page();
        end
        n_tests++;
        if (rx_pending !== 1'b0) begin
            n_fail++; $display("FAIL wrap_end_pending got=%0b exp=0", rx_pending);
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        reset_n        = 1'b1;
        wr_en          = 1'b0;
        wr_addr        = 8'h00;
        wr_byte        = 8'h00;
        wr_flags       = 8'h00;
        rx_ram_switch  = 1'b0;
        rx_ram_rd_addr = 8'h00;
        rx_ram_rd_done = 1'b0;
        rx_clean_all   = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_full_lost();
        test_switch_release_full();
        test_clean_switch();
        test_idle_done_and_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
